regfile_2r1w: RTL and testbench

Parametrised register file: the multi-entry successor to the single 4-bit enable-gated register in the CPU datapath. Provides DEPTH entries of WIDTH bits, one synchronous write port and two independent combinational read ports (operand A and B). Optional write-to-read bypass, optional hardwired zero entry, per-entry written flags and an illegal-write flag. Sits between decode and the ALU.

---
 rtl/regfile_2r1w_if.sv | 30 +++
 rtl/regfile_2r1w.sv | 102 ++++++++++
 tb/tb_regfile_2r1w.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_2r1w_if.sv
// Register file access bundle: one write port and two read ports.
//   master: drives rf_wen/rf_waddr/rf_wdata and both read addresses,
//           receives read data, rf_written and rf_wr_err.
//   slave : the register file side of the same signals.
interface regfile_2r1w_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             rf_wen;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [AW-1:0]    rf_raddr_a;
    logic [AW-1:0]    rf_raddr_b;
    logic [WIDTH-1:0] rf_rdata_a;
    logic [WIDTH-1:0] rf_rdata_b;
    logic [DEPTH-1:0] rf_written;
    logic             rf_wr_err;

    modport master (
        output rf_wen, rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b,
        input  rf_rdata_a, rf_rdata_b, rf_written, rf_wr_err
    );

    modport slave (
        input  rf_wen, rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b,
        output rf_rdata_a, rf_rdata_b, rf_written, rf_wr_err
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Parametrised register file: DEPTH entries of WIDTH bits, one synchronous write
// port and two combinational read ports, with optional write-to-read bypass and
// optional hardwired zero entry.
// Ports:
//   rf_clk  - clock, all state updates on the rising edge
//   rf_rst  - synchronous active-high reset
//   bus     - regfile_2r1w_if slave: write request, read addresses/data,
//             per-entry written flags and registered illegal-write pulse
module regfile_2r1w #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 8,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input logic           rf_clk,
    input logic           rf_rst,
    regfile_2r1w_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;
    logic             wr_err_q, wr_err_d;

    logic waddr_in_range;
    logic waddr_is_zero;
    logic wr_legal;

    // Range check by explicit match so non-power-of-two depths need no
    // magnitude compare against a constant.
    always_comb begin
        waddr_in_range = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rf_waddr == AW'(i)) begin
                waddr_in_range = 1'b1;
            end
        end
    end

    assign waddr_is_zero = (bus.rf_waddr == '0);
    assign wr_legal      = bus.rf_wen && waddr_in_range && !(ZERO_REG && waddr_is_zero);

    // Next state: storage, written flags, error pulse.
    always_comb begin
        written_d = written_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_legal && (bus.rf_waddr == AW'(i))) begin
                mem_d[i]     = bus.rf_wdata;
                written_d[i] = 1'b1;
            end
        end
        wr_err_d = bus.rf_wen && !wr_legal;
    end

    // Reset wins over a simultaneous write; that write is dropped silently.
    always_ff @(posedge rf_clk) begin
        if (rf_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            written_q <= written_d;
            wr_err_q  <= wr_err_d;
        end
    end

    // Read priority: out of range -> 0, zero entry -> 0, bypass, stored value.
    // Out-of-range falls through the loop with the default of 0; wr_legal
    // already excludes out-of-range and zero-entry writes, so the bypass
    // override cannot violate the earlier priorities.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] raddr);
        logic [WIDTH-1:0] rdata;
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == AW'(i)) begin
                rdata = mem_q[i];
            end
        end
        if (ZERO_REG && (raddr == '0)) begin
            rdata = '0;
        end
        if (BYPASS && wr_legal && (raddr == bus.rf_waddr)) begin
            rdata = bus.rf_wdata;
        end
        return rdata;
    endfunction

    always_comb begin
        bus.rf_rdata_a = read_port(bus.rf_raddr_a);
        bus.rf_rdata_b = read_port(bus.rf_raddr_b);
    end

    assign bus.rf_written = written_q;
    assign bus.rf_wr_err  = wr_err_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w. Two instances share clock and reset:
//   dut0: WIDTH=4 DEPTH=8 ZERO_REG=1 BYPASS=1
//   dut1: WIDTH=4 DEPTH=6 ZERO_REG=0 BYPASS=0
// Expected values are queued as stimulus is driven and checked at the
// following falling edge.
module tb_regfile_2r1w;
    localparam int SelA0 = 0, SelB0 = 1, SelWr0 = 2, SelErr0 = 3;
    localparam int SelA1 = 4, SelB1 = 5, SelWr1 = 6, SelErr1 = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;

    regfile_2r1w_if #(.WIDTH(4), .DEPTH(8)) bus0 ();
    regfile_2r1w_if #(.WIDTH(4), .DEPTH(6)) bus1 ();

    regfile_2r1w #(.WIDTH(4), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut0 (
        .rf_clk (clk),
        .rf_rst (rst),
        .bus    (bus0)
    );

    regfile_2r1w #(.WIDTH(4), .DEPTH(6), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut1 (
        .rf_clk (clk),
        .rf_rst (rst),
        .bus    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SelA0:   return 32'(bus0.rf_rdata_a);
            SelB0:   return 32'(bus0.rf_rdata_b);
            SelWr0:  return 32'(bus0.rf_written);
            SelErr0: return 32'(bus0.rf_wr_err);
            SelA1:   return 32'(bus1.rf_rdata_a);
            SelB1:   return 32'(bus1.rf_rdata_b);
            SelWr1:  return 32'(bus1.rf_written);
            default: return 32'(bus1.rf_wr_err);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Sample at the falling edge, away from the capturing edge.
    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sel);
            n_tests++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Advance past a rising edge; inputs change 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset colliding with a write on both instances.
        rst = 1'b1;
        bus0.rf_wen = 1'b1; bus0.rf_waddr = 3'd4; bus0.rf_wdata = 4'b1100;
        bus0.rf_raddr_a = '0; bus0.rf_raddr_b = '0;
        bus1.rf_wen = 1'b1; bus1.rf_waddr = 3'd4; bus1.rf_wdata = 4'b1100;
        bus1.rf_raddr_a = '0; bus1.rf_raddr_b = '0;
        tick();
        rst = 1'b0;
        bus0.rf_wen = 1'b0;
        bus1.rf_wen = 1'b0;
        expect_val("rst_written0", SelWr0, 32'h0);
        expect_val("rst_err0", SelErr0, 32'h0);
        expect_val("rst_written1", SelWr1, 32'h0);
        expect_val("rst_err1", SelErr1, 32'h0);
        check();

        for (int i = 0; i < 8; i++) begin
            tick();
            bus0.rf_raddr_a = 3'(i);
            bus0.rf_raddr_b = 3'(7 - i);
            expect_val("rst_read_a", SelA0, 32'h0);
            expect_val("rst_read_b", SelB0, 32'h0);
            check();
        end

        // Write data activity with write enable low must not disturb storage.
        for (int i = 0; i < 4; i++) begin
            tick();
            bus0.rf_waddr = 3'(i + 2);
            bus0.rf_wdata = 4'(4'b1010 ^ i);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            bus0.rf_raddr_a = 3'(i);
            expect_val("hold_read", SelA0, 32'h0);
            check();
        end
        expect_val("hold_written", SelWr0, 32'h0);
        check();

        // Write then read.
        tick();
        bus0.rf_wen = 1'b1; bus0.rf_waddr = 3'd3; bus0.rf_wdata = 4'b1010;
        tick();
        bus0.rf_waddr = 3'd5; bus0.rf_wdata = 4'b0110;
        tick();
        bus0.rf_wen = 1'b0;
        bus0.rf_raddr_a = 3'd3; bus0.rf_raddr_b = 3'd5;
        expect_val("wr_a3", SelA0, 32'hA);
        expect_val("wr_b5", SelB0, 32'h6);
        expect_val("wr_written", SelWr0, 32'h28);
        expect_val("wr_err", SelErr0, 32'h0);
        check();
        tick();
        bus0.rf_wen = 1'b1; bus0.rf_waddr = 3'd3; bus0.rf_wdata = 4'b0011;
        tick();
        bus0.rf_wen = 1'b0;
        bus0.rf_raddr_b = 3'd3;
        expect_val("rewr_a3", SelA0, 32'h3);
        expect_val("rewr_b3", SelB0, 32'h3);
        check();

        // Bypass on dut0, no bypass on dut1, same-cycle read of the write.
        tick();
        bus0.rf_wen = 1'b1; bus0.rf_waddr = 3'd2; bus0.rf_wdata = 4'b1111;
        bus0.rf_raddr_a = 3'd2; bus0.rf_raddr_b = 3'd2;
        bus1.rf_wen = 1'b1; bus1.rf_waddr = 3'd2; bus1.rf_wdata = 4'b1111;
        bus1.rf_raddr_a = 3'd2; bus1.rf_raddr_b = 3'd2;
        expect_val("byp_a", SelA0, 32'hF);
        expect_val("byp_b", SelB0, 32'hF);
        expect_val("nobyp_a_pre", SelA1, 32'h0);
        expect_val("nobyp_b_pre", SelB1, 32'h0);
        check();
        tick();
        bus0.rf_wen = 1'b0;
        bus1.rf_wen = 1'b0;
        expect_val("byp_a_post", SelA0, 32'hF);
        expect_val("nobyp_a_post", SelA1, 32'hF);
        expect_val("nobyp_b_post", SelB1, 32'hF);
        check();

        // Zero entry: ignored with error on dut0, normal write on dut1.
        tick();
        bus0.rf_wen = 1'b1; bus0.rf_waddr = 3'd0; bus0.rf_wdata = 4'b1001;
        bus0.rf_raddr_a = 3'd0;
        bus1.rf_wen = 1'b1; bus1.rf_waddr = 3'd0; bus1.rf_wdata = 4'b1001;
        bus1.rf_raddr_a = 3'd0;
        expect_val("zero_nobyp_a", SelA0, 32'h0);
        check();
        tick();
        bus0.rf_wen = 1'b0;
        bus1.rf_wen = 1'b0;
        expect_val("zero_a0", SelA0, 32'h0);
        expect_val("zero_written", SelWr0, 32'h2C);
        expect_val("zero_err", SelErr0, 32'h1);
        expect_val("nozero_a0", SelA1, 32'h9);
        expect_val("nozero_err", SelErr1, 32'h0);
        expect_val("nozero_written", SelWr1, 32'h05);
        check();
        tick();
        expect_val("zero_err_clear", SelErr0, 32'h0);
        check();

        // Out of range on DEPTH=6, including back-to-back illegal writes.
        tick();
        bus1.rf_wen = 1'b1; bus1.rf_waddr = 3'd7; bus1.rf_wdata = 4'b0101;
        tick();
        bus1.rf_waddr = 3'd6;
        expect_val("oor_err", SelErr1, 32'h1);
        expect_val("oor_written", SelWr1, 32'h05);
        check();
        tick();
        bus1.rf_wen = 1'b0;
        bus1.rf_raddr_a = 3'd6; bus1.rf_raddr_b = 3'd7;
        expect_val("oor_err_b2b", SelErr1, 32'h1);
        expect_val("oor_read6", SelA1, 32'h0);
        expect_val("oor_read7", SelB1, 32'h0);
        check();
        tick();
        bus1.rf_raddr_a = 3'd5; bus1.rf_raddr_b = 3'd1;
        expect_val("oor_err_clear", SelErr1, 32'h0);
        expect_val("oor_e5", SelA1, 32'h0);
        expect_val("oor_e1", SelB1, 32'h0);
        check();

        // Mid-stream reset colliding with a write, then a write right after.
        tick();
        rst = 1'b1;
        bus0.rf_wen = 1'b1; bus0.rf_waddr = 3'd4; bus0.rf_wdata = 4'b1100;
        bus0.rf_raddr_a = 3'd4; bus0.rf_raddr_b = 3'd3;
        tick();
        rst = 1'b0;
        bus0.rf_wen = 1'b0;
        expect_val("coll_a4", SelA0, 32'h0);
        expect_val("coll_b3", SelB0, 32'h0);
        expect_val("coll_written", SelWr0, 32'h0);
        expect_val("coll_err", SelErr0, 32'h0);
        check();
        tick();
        bus0.rf_wen = 1'b1;
        tick();
        bus0.rf_wen = 1'b0;
        expect_val("post_rst_a4", SelA0, 32'hC);
        expect_val("post_rst_written", SelWr0, 32'h10);
        check();

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
